pwm_carrier_mask_gen: RTL and testbench
=======================================

Name: pwm_carrier_mask_gen

Overview:
- Generates the PWM carrier count and the `maskevent` strobe that commits shadow registers (period, compare values) into their active copies.
- Sits upstream of every shadow-register instance in a PWM channel: drives their `maskevent` and shares `pwm_onoff` with them.
- Its own `period` input is taken from a shadow-register output, so period changes take effect only at mask boundaries.

Parameters:
- COUNT_WIDTH, default `PWMCOUNT_WIDTH (16): width of the carrier counter and of period.
- SKIP_WIDTH, default 4: width of `mask_skip`; used only when PWM_MASK_PRESCALE_EN is defined.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pwm_onoff  in  _pwm_onoff  PWM_ON runs the carrier; PWM_OFF parks it.
- period  in  COUNT_WIDTH  carrier peak value P (shadowed).
- carrier_mode  in  2  00 up-sawtooth, 01 down-sawtooth, 10 up-down triangle, 11 treated as 10.
- mask_mode  in  2  00 mask at zero, 01 mask at peak, 10 mask at both, 11 never.
- mask_skip  in  SKIP_WIDTH  qualifying boundaries skipped between mask events (optional feature only).
- count  out  COUNT_WIDTH  carrier value.
- count_dir  out  1  1 = counting up, 0 = counting down.
- zero_event  out  1  high in any cycle where count==0 while ON.
- peak_event  out  1  high in any cycle where count==P while ON.
- maskevent  out  1  one-cycle strobe to shadow registers.

Behaviour:
- Reset values: count=0, count_dir=1, zero_event=0, peak_event=0, maskevent=0, skip counter=0.
- All outputs are registered and cycle-aligned: event flags describe the count value presented in the same cycle. A shadow register sampling maskevent loads at the end of that cycle, so the new value is active from the next cycle.

Carrier states while pwm_onoff==PWM_OFF (PARKED):
- count=0 in up and triangle modes; count=P in down mode.
- count_dir=1, all events 0, skip counter cleared.

OFF->ON transition:
- The first ON cycle presents the parked value with its events asserted.
- Up/triangle: zero_event=1, and maskevent=1 if mask_mode selects zero.

Counting while ON:
- Up: 0,1,...,P,0,... Period P+1 cycles.
- Down: P,P-1,...,0,P,... Period P+1 cycles.
- Triangle: 0,1,...,P,P-1,...,1,0,1,... Period 2P cycles. Each extreme is held for exactly one cycle. count_dir flips in the cycle after an extreme is presented.

maskevent:
- Asserted when the presented count is a boundary selected by mask_mode: zero_event for 00, peak_event for 01, either for 10, never for 11.
- Up and down modes: zero and peak boundaries occur in adjacent cycles.

Boundary conditions:
- P==0: count stays 0. zero_event and peak_event are both 1 every ON cycle. maskevent is 1 every cycle unless mask_mode=11.
- P reduced below the current count (e.g. unshadowed use):
  - Up: next count is 0.
  - Down: next count is P.
  - Triangle: next count is P and direction becomes down.
- Counter never exceeds 2^COUNT_WIDTH-1; no overflow path exists.
- carrier_mode change while ON takes effect on the next cycle without reset. Counting continues from the current count in the new mode's direction rules.
- pwm_onoff dropping mid-period parks the counter on the next edge, with no maskevent that cycle.
- reset asserted mid-operation clears everything immediately, regardless of clk.

Optional Feature:
- PWM_MASK_PRESCALE_EN defined:
  - A SKIP_WIDTH counter counts qualifying boundaries.
  - maskevent fires on the first qualifying boundary after ON, then on every (mask_skip+1)-th qualifying boundary.
  - The skip counter reloads when maskevent fires and clears while PARKED.
  - mask_skip is sampled when the counter reloads.
- Not defined:
  - mask_skip port is absent; no skip logic is generated.
  - maskevent fires on every qualifying boundary.

Test Plan:
- Reset mid-count in up mode, P=5, count=3 -> count=0, all events 0 immediately (asynchronous), before the next clk edge.
- Up mode, P=4, mask_mode=00, turn ON -> count 0,1,2,3,4,0. maskevent high on count=0 cycles only (cycles 0 and 5). peak_event at count=4.
- Triangle, P=3, mask_mode=10 -> count 0,1,2,3,2,1,0,1. maskevent at counts 0,3,0. count_dir 1,1,1,1,0,0,0,1.
- P=0, mask_mode=01, ON for 4 cycles -> count 0 throughout; zero_event, peak_event and maskevent high all 4 cycles.
- Down mode, P=6, reduce P to 2 when count=5 -> next count=2, then 1,0,2. Drop pwm_onoff at count=1 -> parks at P=2, with no maskevent in that cycle.
- With PWM_MASK_PRESCALE_EN, up mode, P=2, mask_mode=00, mask_skip=2 -> maskevent on 1st, 4th and 7th zero crossings only.

Source files
------------

// File: rtl/pwm_carrier_mask_gen.sv
//-----------------------------------------------------------------------------
// pwm_carrier_mask_gen
//
// Purpose:
//   Generates the PWM carrier count (up-sawtooth, down-sawtooth or up-down
//   triangle) together with zero/peak boundary flags and the one-cycle
//   maskevent strobe that commits shadow registers into their active copies.
//   All outputs are registered; the flags describe the count presented in
//   the same cycle.
//
// Optional feature (compile-time macro PWM_MASK_PRESCALE_EN):
//   When defined, a skip counter lets maskevent fire on the first qualifying
//   boundary after ON and then on every (mask_skip+1)-th qualifying boundary.
//   When undefined, the mask_skip port and the skip logic do not exist and
//   maskevent fires on every qualifying boundary.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   pwm_onoff     in   1 = run the carrier, 0 = park it
//   period        in   carrier peak value P (from a shadow register)
//   carrier_mode  in   00 up, 01 down, 10 triangle, 11 triangle
//   mask_mode     in   00 zero, 01 peak, 10 both, 11 never
//   mask_skip     in   boundaries skipped between mask events (macro only)
//   count         out  carrier value
//   count_dir     out  1 = counting up, 0 = counting down
//   zero_event    out  count==0 while ON
//   peak_event    out  count==P while ON
//   maskevent     out  one-cycle commit strobe for shadow registers
//-----------------------------------------------------------------------------
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

module pwm_carrier_mask_gen #(
    parameter int COUNT_WIDTH = `PWMCOUNT_WIDTH,
    parameter int SKIP_WIDTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pwm_onoff,
    input  logic [COUNT_WIDTH-1:0] period,
    input  logic [1:0]             carrier_mode,
    input  logic [1:0]             mask_mode,
`ifdef PWM_MASK_PRESCALE_EN
    input  logic [SKIP_WIDTH-1:0]  mask_skip,
`endif
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   count_dir,
    output logic                   zero_event,
    output logic                   peak_event,
    output logic                   maskevent
);

    localparam logic PWM_ON = 1'b1;

    typedef enum logic [1:0] {
        CM_UP      = 2'b00,
        CM_DOWN    = 2'b01,
        CM_TRI     = 2'b10,
        CM_TRI_ALT = 2'b11
    } carrier_mode_e;

    typedef enum logic [1:0] {
        MM_ZERO  = 2'b00,
        MM_PEAK  = 2'b01,
        MM_BOTH  = 2'b10,
        MM_NEVER = 2'b11
    } mask_mode_e;

    typedef logic [SKIP_WIDTH-1:0] skip_t;

    carrier_mode_e          w_mode;
    mask_mode_e             w_mmode;
    logic [COUNT_WIDTH-1:0] r_count, w_count_nxt;
    logic                   r_dir, w_dir_nxt;
    logic                   r_on, w_on_nxt;
    logic                   r_zero, r_peak, r_mask;
    logic                   w_zero_nxt, w_peak_nxt, w_qual, w_mask_nxt;

    assign w_mode  = carrier_mode_e'(carrier_mode);
    assign w_mmode = mask_mode_e'(mask_mode);

    // Next carrier value and direction. r_on remembers whether the previous
    // presented cycle was ON, so the first ON cycle re-presents the parked
    // value (with its events) instead of advancing.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_count_nxt = '0;
        w_dir_nxt   = 1'b1;
        w_on_nxt    = 1'b0;
        if (pwm_onoff != PWM_ON) begin
            w_count_nxt = (w_mode == CM_DOWN) ? period : '0;
        end else if (!r_on) begin
            w_on_nxt    = 1'b1;
            w_count_nxt = (w_mode == CM_DOWN) ? period : '0;
            // A down carrier is already heading down in its first ON cycle.
            w_dir_nxt   = (w_mode != CM_DOWN);
        end else begin
            w_on_nxt = 1'b1;
            case (w_mode)
                CM_UP: begin
                    w_dir_nxt   = 1'b1;
                    // ">=" also covers P lowered below the current count.
                    w_count_nxt = (r_count >= period) ? '0 : r_count + 1'b1;
                end
                CM_DOWN: begin
                    w_dir_nxt   = 1'b0;
                    w_count_nxt = (r_count == '0 || r_count > period) ?
                                  period : r_count - 1'b1;
                end
                default: begin
                    if (period == '0) begin
                        w_count_nxt = '0;
                        w_dir_nxt   = 1'b1;
                    end else if (r_count > period) begin
                        w_count_nxt = period;
                        w_dir_nxt   = 1'b0;
                    end else if (r_dir) begin
                        // The peak is presented with dir still up; the flip
                        // shows up together with the first step down.
                        if (r_count == period) begin
                            w_count_nxt = period - 1'b1;
                            w_dir_nxt   = 1'b0;
                        end else begin
                            w_count_nxt = r_count + 1'b1;
                            w_dir_nxt   = 1'b1;
                        end
                    end else begin
                        if (r_count == '0) begin
                            w_count_nxt = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
                            w_dir_nxt   = 1'b1;
                        end else begin
                            w_count_nxt = r_count - 1'b1;
                            w_dir_nxt   = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign w_zero_nxt = w_on_nxt && (w_count_nxt == '0);
    assign w_peak_nxt = w_on_nxt && (w_count_nxt == period);

    always_comb begin
        w_qual = 1'b0;
        case (w_mmode)
            MM_ZERO:  w_qual = w_zero_nxt;
            MM_PEAK:  w_qual = w_peak_nxt;
            MM_BOTH:  w_qual = w_zero_nxt | w_peak_nxt;
            MM_NEVER: w_qual = 1'b0;
            default:  w_qual = 1'b0;
        endcase
    end

`ifdef PWM_MASK_PRESCALE_EN
    skip_t r_skip_cnt, w_skip_nxt;

    // The counter holds the number of qualifying boundaries still to skip;
    // zero means the next one fires and reloads mask_skip.
    always_comb begin
        w_mask_nxt = w_qual && (r_skip_cnt == '0);
        w_skip_nxt = r_skip_cnt;
        if (!w_on_nxt)
            w_skip_nxt = '0;
        else if (w_qual)
            w_skip_nxt = (r_skip_cnt == '0) ? mask_skip : r_skip_cnt - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_skip_cnt <= '0;
        else       r_skip_cnt <= w_skip_nxt;
    end
`else
    assign w_mask_nxt = w_qual;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_dir   <= 1'b1;
            r_on    <= 1'b0;
            r_zero  <= 1'b0;
            r_peak  <= 1'b0;
            r_mask  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_dir   <= w_dir_nxt;
            r_on    <= w_on_nxt;
            r_zero  <= w_zero_nxt;
            r_peak  <= w_peak_nxt;
            r_mask  <= w_mask_nxt;
        end
    end

    assign count      = r_count;
    assign count_dir  = r_dir;
    assign zero_event = r_zero;
    assign peak_event = r_peak;
    assign maskevent  = r_mask;

endmodule

// File: tb/tb_pwm_carrier_mask_gen.sv
//-----------------------------------------------------------------------------
// tb_pwm_carrier_mask_gen
//
// Self-checking bench. A behavioural model derives the expected carrier from
// the cycle index since ON (modulo arithmetic per carrier shape) and the
// mask from the index of the qualifying boundary; a compare process checks
// it on every falling edge. Directed sequences with literal expectations pin
// the model, and randomized segments exercise it.
//-----------------------------------------------------------------------------
module tb_pwm_carrier_mask_gen;

    localparam int CW = 16;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          pwm_onoff;
    logic [CW-1:0] period;
    logic [1:0]    carrier_mode;
    logic [1:0]    mask_mode;
`ifdef PWM_MASK_PRESCALE_EN
    logic [SW-1:0] mask_skip;
`endif
    logic [CW-1:0] count;
    logic          count_dir;
    logic          zero_event;
    logic          peak_event;
    logic          maskevent;

    pwm_carrier_mask_gen #(.COUNT_WIDTH(CW), .SKIP_WIDTH(SW)) dut (
        .clk          (clk),
        .reset        (reset),
        .pwm_onoff    (pwm_onoff),
        .period       (period),
        .carrier_mode (carrier_mode),
        .mask_mode    (mask_mode),
`ifdef PWM_MASK_PRESCALE_EN
        .mask_skip    (mask_skip),
`endif
        .count        (count),
        .count_dir    (count_dir),
        .zero_event   (zero_event),
        .peak_event   (peak_event),
        .maskevent    (maskevent)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    //------------------------------------------------------------------
    // Behavioural model: k = cycles since the first ON cycle,
    // q = qualifying boundaries seen since ON. Mode/P/skip are held
    // constant for a whole ON run when the model is trusted.
    //------------------------------------------------------------------
    int            k;
    int            q;
    bit            on_prev;
    logic [CW-1:0] e_count;
    bit            e_dir, e_zero, e_peak, e_mask;

    always @(posedge clk or posedge reset) begin
        int kk, p, c, m, qq;
        bit d, z, pk, qual, mk;
        if (reset) begin
            on_prev <= 1'b0; k <= 0; q <= 0;
            e_count <= '0; e_dir <= 1'b1; e_zero <= 1'b0; e_peak <= 1'b0; e_mask <= 1'b0;
        end else if (!pwm_onoff) begin
            on_prev <= 1'b0; k <= 0; q <= 0;
            e_count <= (carrier_mode == 2'b01) ? period : '0;
            e_dir <= 1'b1; e_zero <= 1'b0; e_peak <= 1'b0; e_mask <= 1'b0;
        end else begin
            kk = on_prev ? k + 1 : 0;
            p  = int'(period);
            case (carrier_mode)
                2'b00: begin c = kk % (p + 1); d = 1'b1; end
                2'b01: begin c = p - (kk % (p + 1)); d = 1'b0; end
                default: begin
                    if (p == 0) begin
                        c = 0; d = 1'b1;
                    end else begin
                        m = kk % (2 * p);
                        c = (m <= p) ? m : 2 * p - m;
                        d = (kk == 0) ? 1'b1 : (m == 0) ? 1'b0 : (m <= p);
                    end
                end
            endcase
            z  = (c == 0);
            pk = (c == p);
            case (mask_mode)
                2'b00:   qual = z;
                2'b01:   qual = pk;
                2'b10:   qual = z | pk;
                default: qual = 1'b0;
            endcase
            qq = on_prev ? q : 0;
            mk = 1'b0;
            if (qual) begin
`ifdef PWM_MASK_PRESCALE_EN
                mk = ((qq % (int'(mask_skip) + 1)) == 0);
`else
                mk = 1'b1;
`endif
                qq = qq + 1;
            end
            on_prev <= 1'b1; k <= kk; q <= qq;
            e_count <= c[CW-1:0]; e_dir <= d; e_zero <= z; e_peak <= pk; e_mask <= mk;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("model_count", 32'(count), 32'(e_count));
            check("model_dir",   32'(count_dir),  32'(e_dir));
            check("model_zero",  32'(zero_event), 32'(e_zero));
            check("model_peak",  32'(peak_event), 32'(e_peak));
            check("model_mask",  32'(maskevent),  32'(e_mask));
        end
    end

    // Literal expectation tables for the directed sequences.
    int up_cnt  [6] = '{0, 1, 2, 3, 4, 0};
    int up_mask [6] = '{1, 0, 0, 0, 0, 1};
    int up_peak [6] = '{0, 0, 0, 0, 1, 0};
    int tr_cnt  [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
    int tr_mask [8] = '{1, 0, 0, 1, 0, 0, 1, 0};
    int tr_dir  [8] = '{1, 1, 1, 1, 0, 0, 0, 1};
    int dn_cnt  [8] = '{6, 5, 2, 1, 0, 2, 1, 2};
    int dn_mask [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    int dn_peak [8] = '{1, 0, 1, 0, 0, 1, 0, 0};
    int dn_zero [8] = '{0, 0, 0, 0, 1, 0, 0, 0};

    task automatic park_and_set(input logic [1:0] cm, input logic [CW-1:0] p, input logic [1:0] mm);
        @(negedge clk);
        pwm_onoff    = 1'b0;
        carrier_mode = cm;
        period       = p;
        mask_mode    = mm;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset        = 1'b1;
        pwm_onoff    = 1'b0;
        period       = '0;
        carrier_mode = 2'b00;
        mask_mode    = 2'b00;
`ifdef PWM_MASK_PRESCALE_EN
        mask_skip    = '0;
`endif
        #3;
        check("rst_count", 32'(count), 0);
        check("rst_dir",   32'(count_dir), 1);
        check("rst_zero",  32'(zero_event), 0);
        check("rst_peak",  32'(peak_event), 0);
        check("rst_mask",  32'(maskevent), 0);
        @(negedge clk);
        reset = 1'b0;
        check_en = 1'b1;

        // Up sawtooth, P=4, mask at zero.
        park_and_set(2'b00, 16'd4, 2'b00);
        pwm_onoff = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("up_count", 32'(count), up_cnt[i]);
            check("up_mask",  32'(maskevent), up_mask[i]);
            check("up_peak",  32'(peak_event), up_peak[i]);
        end

        // Triangle, P=3, mask at both.
        park_and_set(2'b10, 16'd3, 2'b10);
        pwm_onoff = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("tri_count", 32'(count), tr_cnt[i]);
            check("tri_mask",  32'(maskevent), tr_mask[i]);
            check("tri_dir",   32'(count_dir), tr_dir[i]);
        end

        // P=0, mask at peak: everything fires every ON cycle.
        park_and_set(2'b00, 16'd0, 2'b01);
        pwm_onoff = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("p0_count", 32'(count), 0);
            check("p0_zero",  32'(zero_event), 1);
            check("p0_peak",  32'(peak_event), 1);
            check("p0_mask",  32'(maskevent), 1);
        end

        // Randomized runs with parameters held constant per ON run.
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            pwm_onoff    = 1'b0;
            carrier_mode = 2'($urandom_range(0, 3));
            mask_mode    = 2'($urandom_range(0, 3));
            period       = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom_range(0, 9));
`ifdef PWM_MASK_PRESCALE_EN
            mask_skip    = 4'($urandom_range(0, 3));
`endif
            repeat ($urandom_range(1, 3)) @(negedge clk);
            pwm_onoff = 1'b1;
            repeat ($urandom_range(4, 40)) @(negedge clk);
        end

        // Down sawtooth with P cut from 6 to 2 at count 5, then drop ON at count 1.
        park_and_set(2'b01, 16'd6, 2'b00);
        check_en  = 1'b0;
        pwm_onoff = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("dn_count", 32'(count), dn_cnt[i]);
            check("dn_mask",  32'(maskevent), dn_mask[i]);
            check("dn_peak",  32'(peak_event), dn_peak[i]);
            check("dn_zero",  32'(zero_event), dn_zero[i]);
            if (i == 1) period = 16'd2;
            if (i == 6) pwm_onoff = 1'b0;
        end
        check("dn_park_dir", 32'(count_dir), 1);

        // Asynchronous reset mid-count in up mode.
        park_and_set(2'b00, 16'd5, 2'b00);
        pwm_onoff = 1'b1;
        repeat (4) @(negedge clk);
        check("pre_rst_count", 32'(count), 3);
        #1 reset = 1'b1;
        #1;
        check("async_rst_count", 32'(count), 0);
        check("async_rst_zero",  32'(zero_event), 0);
        check("async_rst_peak",  32'(peak_event), 0);
        check("async_rst_mask",  32'(maskevent), 0);
        check("async_rst_dir",   32'(count_dir), 1);
        pwm_onoff = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_en = 1'b1;

`ifdef PWM_MASK_PRESCALE_EN
        // Prescaled mask: up, P=2, zero mask, skip 2 -> zero crossings 1, 4, 7.
        park_and_set(2'b00, 16'd2, 2'b00);
        mask_skip = 4'd2;
        @(negedge clk);
        pwm_onoff = 1'b1;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            check("pre_zero", 32'(zero_event), (i % 3 == 0) ? 1 : 0);
            check("pre_mask", 32'(maskevent),  (i % 9 == 0) ? 1 : 0);
        end
`endif

        @(negedge clk);
        pwm_onoff = 1'b0;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
